hs_sync_rx: RTL and testbench

- Destination-side controller for a 4-phase req/ack bus crossing into the CLK domain.
- Synchronizes the incoming level request through a NUM_STAGES multi-flop chain.
- Captures the source-held data bus once the request arrives and presents it to a local consumer with valid/ready.
- Drives a registered acknowledge back to the source domain and sequences the full req/ack return-to-zero protocol.

---
 rtl/hs_sync_rx.sv | 85 ++++++++
 tb/tb_hs_sync_rx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_sync_rx.sv
// hs_sync_rx: destination side of a 4-phase req/ack bus crossing into CLK.
// The level request is brought in through a multi-flop synchronizer. The
// source-held data bus is captured once and offered to a local consumer with
// valid/ready. A flop-driven acknowledge then runs the return-to-zero handshake.
module hs_sync_rx #(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ASYNC_REQ,
  input  logic [BUS_WIDTH-1:0] ASYNC_DATA,
  input  logic                 READY,
  output logic [BUS_WIDTH-1:0] SYNC_DATA,
  output logic                 VALID,
  output logic                 ACK,
  output logic                 BUSY,
  output logic [CNT_WIDTH-1:0] XFER_CNT
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    ACK_HI  = 2'd2
  } state_t;

  state_t                state;
  logic [NUM_STAGES-1:0] sync_q;
  logic                  req_s;

  // Shift the raw request through the synchronizer chain; only the last stage is trusted.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[NUM_STAGES-2:0], ASYNC_REQ};
    end
  end

  assign req_s = sync_q[NUM_STAGES-1];

  // Handshake sequencer: capture on request, hold until accepted, then keep ACK up until the request returns to zero.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      SYNC_DATA <= '0;
      VALID     <= 1'b0;
      ACK       <= 1'b0;
      XFER_CNT  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_s) begin
            SYNC_DATA <= ASYNC_DATA;
            VALID     <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (READY) begin
            VALID    <= 1'b0;
            ACK      <= 1'b1;
            XFER_CNT <= XFER_CNT + CNT_WIDTH'(1);
            state    <= ACK_HI;
          end
        end
        ACK_HI: begin
          if (!req_s) begin
            ACK   <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          VALID <= 1'b0;
          ACK   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_hs_sync_rx.sv
// tb_hs_sync_rx: scoreboard bench for hs_sync_rx. The source side queues the
// word it offers. A negedge monitor pops the queue on every accepted word and
// keeps the expected transfer count.
module tb_hs_sync_rx;
  parameter int NUM_STAGES = 2;
  parameter int BUS_WIDTH  = 8;
  parameter int CNT_WIDTH  = 8;
  localparam int TIMEOUT   = 400;

  logic                 CLK;
  logic                 RST;
  logic                 ASYNC_REQ;
  logic [BUS_WIDTH-1:0] ASYNC_DATA;
  logic                 READY;
  logic [BUS_WIDTH-1:0] SYNC_DATA;
  logic                 VALID;
  logic                 ACK;
  logic                 BUSY;
  logic [CNT_WIDTH-1:0] XFER_CNT;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic [BUS_WIDTH-1:0] exp_q[$];
  logic stream_done;

  hs_sync_rx #(
    .NUM_STAGES(NUM_STAGES),
    .BUS_WIDTH (BUS_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ASYNC_REQ (ASYNC_REQ),
    .ASYNC_DATA(ASYNC_DATA),
    .READY     (READY),
    .SYNC_DATA (SYNC_DATA),
    .VALID     (VALID),
    .ACK       (ACK),
    .BUSY      (BUSY),
    .XFER_CNT  (XFER_CNT)
  );

  // free-running destination clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cnt_model();
    return 32'(exp_cnt % (1 << CNT_WIDTH));
  endfunction

  // monitor: an accept happens on the next rising edge whenever VALID and READY are both high here
  always @(negedge CLK) begin
    if (RST && VALID) begin
      checkOutput("ack_low_while_valid", 32'(ACK), 32'd0);
      if (READY) begin
        if (exp_q.size() == 0) begin
          checkOutput("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
          checkOutput("accepted_data", 32'(SYNC_DATA), 32'(exp_q.pop_front()));
        end
        exp_cnt++;
      end
    end
  end

  task automatic waitVal(input string name, input logic val_level, input logic use_ack);
    int n;
    n = 0;
    while (n < TIMEOUT) begin
      @(negedge CLK);
      if ((use_ack ? ACK : VALID) == val_level) break;
      n++;
    end
    if (n >= TIMEOUT) checkOutput(name, 32'd0, 32'd1);
  endtask

  // full four-phase source transaction
  task automatic applyStimulus(input logic [BUS_WIDTH-1:0] data);
    @(posedge CLK);
    #2;
    ASYNC_DATA = data;
    exp_q.push_back(data);
    ASYNC_REQ = 1'b1;
    waitVal("timeout_ack_rise", 1'b1, 1'b1);
    @(posedge CLK);
    #2;
    ASYNC_REQ = 1'b0;
    waitVal("timeout_ack_fall", 1'b0, 1'b1);
  endtask

  // count rising edges until VALID is seen high, starting from the next edge
  task automatic edgesToValid(output int e);
    e = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (VALID) begin
        e = i;
        break;
      end
    end
  endtask

  initial begin
    int e;
    logic [BUS_WIDTH-1:0] base;
    RST = 1'b0;
    ASYNC_REQ = 1'b0;
    ASYNC_DATA = '0;
    READY = 1'b0;
    stream_done = 1'b0;

    // reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkOutput("reset_valid", 32'(VALID), 32'd0);
    checkOutput("reset_ack", 32'(ACK), 32'd0);
    checkOutput("reset_busy", 32'(BUSY), 32'd0);
    checkOutput("reset_cnt", 32'(XFER_CNT), 32'd0);
    checkOutput("reset_data", 32'(SYNC_DATA), 32'd0);
    @(posedge CLK);
    #2 RST = 1'b1;

    // single transfer with READY held high
    @(posedge CLK);
    #2;
    ASYNC_DATA = 8'hA5;
    exp_q.push_back(8'hA5);
    ASYNC_REQ = 1'b1;
    READY = 1'b1;
    edgesToValid(e);
    checkOutput("valid_latency", 32'(e), 32'(NUM_STAGES + 1));
    checkOutput("s1_data", 32'(SYNC_DATA), 32'hA5);
    @(negedge CLK);
    checkOutput("s1_valid_one_cycle", 32'(VALID), 32'd0);
    checkOutput("s1_ack_rise", 32'(ACK), 32'd1);
    @(posedge CLK);
    #2 ASYNC_REQ = 1'b0;
    e = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (!ACK) begin
        e = i;
        break;
      end
    end
    checkOutput("ack_fall_latency", 32'(e), 32'(NUM_STAGES + 1));
    checkOutput("s1_busy_idle", 32'(BUSY), 32'd0);
    checkOutput("s1_cnt", 32'(XFER_CNT), 32'd1);

    // backpressure
    READY = 1'b0;
    @(posedge CLK);
    #2;
    ASYNC_DATA = 8'h3C;
    exp_q.push_back(8'h3C);
    ASYNC_REQ = 1'b1;
    waitVal("timeout_valid_bp", 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      checkOutput("bp_valid", 32'(VALID), 32'd1);
      checkOutput("bp_data", 32'(SYNC_DATA), 32'h3C);
      checkOutput("bp_busy", 32'(BUSY), 32'd1);
    end
    @(posedge CLK);
    #1 READY = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("bp_ack_on_accept", 32'(ACK), 32'd1);
    checkOutput("bp_valid_drop", 32'(VALID), 32'd0);
    @(posedge CLK);
    #2 ASYNC_REQ = 1'b0;
    waitVal("timeout_ack_fall_bp", 1'b0, 1'b1);
    checkOutput("bp_cnt", 32'(XFER_CNT), cnt_model());

    // stream of 300 back-to-back transfers with random READY
    base = BUS_WIDTH'($urandom);
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          applyStimulus(base + BUS_WIDTH'(i));
          repeat ($urandom_range(0, 2)) @(posedge CLK);
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge CLK);
          #1 READY = ($urandom_range(0, 3) != 0);
        end
      end
    join
    checkOutput("stream_all_received", 32'(exp_q.size()), 32'd0);
    checkOutput("stream_cnt", 32'(XFER_CNT), cnt_model());

    // reset while presenting, request still held
    READY = 1'b0;
    @(posedge CLK);
    #2;
    ASYNC_DATA = BUS_WIDTH'($urandom);
    exp_q.push_back(ASYNC_DATA);
    ASYNC_REQ = 1'b1;
    waitVal("timeout_valid_rst", 1'b1, 1'b0);
    @(posedge CLK);
    #2 RST = 1'b0;
    exp_cnt = 0;
    #1;
    checkOutput("async_rst_valid", 32'(VALID), 32'd0);
    checkOutput("async_rst_ack", 32'(ACK), 32'd0);
    checkOutput("async_rst_busy", 32'(BUSY), 32'd0);
    checkOutput("async_rst_cnt", 32'(XFER_CNT), 32'd0);
    repeat (2) @(posedge CLK);
    #2 RST = 1'b1;
    edgesToValid(e);
    checkOutput("recapture_latency", 32'(e), 32'(NUM_STAGES + 1));
    @(posedge CLK);
    #1 READY = 1'b1;
    waitVal("timeout_ack_rise_rst", 1'b1, 1'b1);
    @(posedge CLK);
    #2 ASYNC_REQ = 1'b0;
    waitVal("timeout_ack_fall_rst", 1'b0, 1'b1);
    checkOutput("rst_cnt_after", 32'(XFER_CNT), 32'd1);

    // request withdrawn while presenting
    READY = 1'b0;
    @(posedge CLK);
    #2;
    ASYNC_DATA = 8'h5A;
    exp_q.push_back(8'h5A);
    ASYNC_REQ = 1'b1;
    waitVal("timeout_valid_pv", 1'b1, 1'b0);
    @(posedge CLK);
    #2 ASYNC_REQ = 1'b0;
    repeat (NUM_STAGES + 2) @(posedge CLK);
    @(negedge CLK);
    checkOutput("pv_still_valid", 32'(VALID), 32'd1);
    @(posedge CLK);
    #1 READY = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("pv_ack_high", 32'(ACK), 32'd1);
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("pv_ack_one_cycle", 32'(ACK), 32'd0);
    checkOutput("pv_idle", 32'(BUSY), 32'd0);
    checkOutput("pv_cnt", 32'(XFER_CNT), cnt_model());

    // sub-cycle glitch straddling an edge
    @(posedge CLK);
    #2;
    ASYNC_DATA = 8'hC3;
    exp_q.push_back(8'hC3);
    #6 ASYNC_REQ = 1'b1;
    #4 ASYNC_REQ = 1'b0;
    repeat (12) @(posedge CLK);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    @(negedge CLK);
    checkOutput("glitch_busy", 32'(BUSY), 32'd0);
    checkOutput("glitch_ack", 32'(ACK), 32'd0);
    checkOutput("glitch_valid", 32'(VALID), 32'd0);
    checkOutput("glitch_cnt", 32'(XFER_CNT), cnt_model());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
